// File: rtl/nav_controller.sv
// Navigation command sequencer: speed-mode selection, position zeroing and a
// charge/jump/cooldown sequence with abort and a saturating jump counter.
module nav_controller #(
  parameter int unsigned k               = 16,
  parameter int unsigned CHARGE_CYCLES   = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [1:0]     cmd_speed,
  input  logic [3*k-1:0] cmd_target,
  output logic [3:0]     mode_selector,
  output logic [3:0]     pos_mode,
  output logic [3*k-1:0] jump_position,
  output logic           cmd_err,
  output logic [7:0]     jump_count
);

  localparam int unsigned CntMax = (CHARGE_CYCLES > COOLDOWN_CYCLES) ? CHARGE_CYCLES
                                                                     : COOLDOWN_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ChargeLoad   = CntW'(CHARGE_CYCLES - 1);
  localparam logic [CntW-1:0] CooldownLoad = CntW'(COOLDOWN_CYCLES - 1);

  localparam logic [1:0] OpSetMode = 2'b00;
  localparam logic [1:0] OpJump    = 2'b01;
  localparam logic [1:0] OpZero    = 2'b10;
  localparam logic [1:0] OpAbort   = 2'b11;

  localparam logic [3:0] ModeZero    = 4'b0001;
  localparam logic [3:0] PosZero     = 4'b0001;
  localparam logic [3:0] PosSublight = 4'b0010;
  localparam logic [3:0] PosJump     = 4'b0100;

  typedef enum logic [2:0] {StIdle, StZero, StCharge, StJump, StCooldown} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      mode_q, mode_d;
  logic [3:0]      saved_q, saved_d;
  logic [3:0]      pos_q, pos_d;
  logic [3*k-1:0]  jpos_q, jpos_d;
  logic            err_q, err_d;
  logic [7:0]      jcnt_q, jcnt_d;
  logic            accept;

  assign cmd_ready     = (state_q == StIdle) || (state_q == StCharge);
  assign accept        = cmd_valid & cmd_ready;
  assign mode_selector = mode_q;
  assign pos_mode      = pos_q;
  assign jump_position = jpos_q;
  assign cmd_err       = err_q;
  assign jump_count    = jcnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    saved_d = saved_q;
    jpos_d  = jpos_q;
    err_d   = 1'b0;
    jcnt_d  = jcnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op)
            OpSetMode: begin
              mode_d  = 4'b0001 << cmd_speed;
              saved_d = 4'b0001 << cmd_speed;
            end
            OpJump: begin
              jpos_d  = cmd_target;
              mode_d  = ModeZero;
              cnt_d   = ChargeLoad;
              state_d = StCharge;
            end
            OpZero:  state_d = StZero;
            OpAbort: ;
          endcase
        end
      end
      StZero: state_d = StIdle;
      StCharge: begin
        // Abort wins even on the final charge cycle.
        if (accept && (cmd_op == OpAbort)) begin
          state_d = StIdle;
          mode_d  = saved_q;
          cnt_d   = '0;
        end else begin
          err_d = accept;
          if (cnt_q == '0) begin
            state_d = StJump;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StJump: begin
        if (jcnt_q != 8'hff) begin
          jcnt_d = jcnt_q + 8'd1;
        end
        mode_d  = saved_q;
        cnt_d   = CooldownLoad;
        state_d = StCooldown;
      end
      StCooldown: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StZero:  pos_d = PosZero;
      StJump:  pos_d = PosJump;
      default: pos_d = PosSublight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= ModeZero;
      saved_q <= ModeZero;
      pos_q   <= PosZero;
      jpos_q  <= '0;
      err_q   <= 1'b0;
      jcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      saved_q <= saved_d;
      pos_q   <= pos_d;
      jpos_q  <= jpos_d;
      err_q   <= err_d;
      jcnt_q  <= jcnt_d;
    end
  end

endmodule
